// File: rtl/mem_arbiter.sv
// Arbitrates a single-port memory between a CPU with absolute priority and an
// auxiliary req/ack master that is served only in the CPU's idle cycles.
module mem_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cpu_addr,
  input  logic             cpu_rstrb,
  input  logic [31:0]      cpu_wdata,
  input  logic [3:0]       cpu_wmask,
  output logic [31:0]      cpu_rdata,
  input  logic             aux_req,
  input  logic             aux_we,
  input  logic [31:0]      aux_addr,
  input  logic [31:0]      aux_wdata,
  input  logic [3:0]       aux_wmask,
  output logic             aux_ack,
  output logic [31:0]      aux_rdata,
  output logic [31:0]      mem_addr,
  output logic             mem_rstrb,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {StIdle, StRdWait, StAck} state_e;

  state_e           state_q, state_d;
  logic             cpu_act, aux_issue, aux_blocked;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      aux_rdata_q, cpu_rdata_q;
  logic             cpu_rd_q;

  // Gating the issue with rst keeps aux requests off the memory bus during reset.
  assign cpu_act     = cpu_rstrb | (|cpu_wmask);
  assign aux_issue   = rst & (state_q == StIdle) & aux_req & ~cpu_act;
  assign aux_blocked = (state_q == StIdle) & aux_req & cpu_act;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (aux_issue) state_d = aux_we ? StAck : StRdWait;
      end
      StRdWait: state_d = StAck;
      StAck:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (aux_blocked && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    mem_addr  = aux_addr;
    mem_wdata = aux_wdata;
    mem_rstrb = 1'b0;
    mem_wmask = 4'h0;
    if (cpu_act) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_rstrb = cpu_rstrb;
      mem_wmask = cpu_wmask;
    end else if (aux_issue) begin
      mem_rstrb = ~aux_we;
      mem_wmask = aux_we ? aux_wmask : 4'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      aux_rdata_q <= 32'h0;
      cpu_rdata_q <= 32'h0;
      cpu_rd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cpu_rd_q <= cpu_rstrb;
      if (state_q == StRdWait) aux_rdata_q <= mem_rdata;
      if (cpu_rd_q)            cpu_rdata_q <= mem_rdata;
    end
  end

  // Outside its own read-return cycle the CPU sees its last captured word.
  assign cpu_rdata    = cpu_rd_q ? mem_rdata : cpu_rdata_q;
  assign aux_ack      = (state_q == StAck);
  assign aux_rdata    = aux_rdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory; a second
// instance with a 4-bit counter shares all inputs to exercise saturation.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata, mem_rdata;
  logic        cpu_rstrb, aux_req, aux_we;
  logic [3:0]  cpu_wmask, aux_wmask;
  logic [31:0] cpu_rdata, aux_rdata, mem_addr, mem_wdata;
  logic        aux_ack, mem_rstrb;
  logic [3:0]  mem_wmask;
  logic [15:0] conflict_cnt;
  logic [31:0] s_cpu_rdata, s_aux_rdata, s_mem_addr, s_mem_wdata;
  logic        s_aux_ack, s_mem_rstrb;
  logic [3:0]  s_mem_wmask, s_conflict_cnt;
  logic [31:0] mem [64];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mem_arbiter u_dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rstrb(cpu_rstrb),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_wmask(aux_wmask), .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  mem_arbiter #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rstrb(cpu_rstrb),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_rdata(s_cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_wmask(aux_wmask), .aux_ack(s_aux_ack), .aux_rdata(s_aux_rdata),
    .mem_addr(s_mem_addr), .mem_rstrb(s_mem_rstrb), .mem_wdata(s_mem_wdata),
    .mem_wmask(s_mem_wmask), .mem_rdata(mem_rdata), .conflict_cnt(s_conflict_cnt)
  );

  // Memory: read data valid the cycle after the strobe, byte writes at the edge.
  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
    for (int b = 0; b < 4; b++) begin
      if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aux_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask);
    aux_req   = 1'b1;
    aux_we    = we;
    aux_addr  = addr;
    aux_wdata = wdata;
    aux_wmask = wmask;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0]    = 32'h0000_0013;
    mem[17]   = 32'hCAFE_F00D;
    mem[32]   = 32'h1234_5678;
    mem_rdata = 32'h0;
    rst = 1'b0;
    cpu_addr = 32'h0; cpu_rstrb = 1'b0; cpu_wdata = 32'h0; cpu_wmask = 4'h0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = 32'h0; aux_wdata = 32'h0; aux_wmask = 4'h0;

    // Reset state
    repeat (2) tick();
    check("rst_ack", 32'(aux_ack), 32'h0);
    check("rst_cnt", 32'(conflict_cnt), 32'h0);
    check("rst_aux_rdata", aux_rdata, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    tick();
    rst = 1'b1;

    // Aux write with CPU idle, then read back
    tick();
    aux_drive(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    #1;
    check("wr_mask", 32'(mem_wmask), 32'hF);
    check("wr_addr", mem_addr, 32'h40);
    check("wr_rstrb", 32'(mem_rstrb), 32'h0);
    check("wr_ack_n", 32'(aux_ack), 32'h0);
    tick();
    check("wr_ack_n1", 32'(aux_ack), 32'h1);
    aux_req = 1'b0;
    tick();
    check("wr_ack_off", 32'(aux_ack), 32'h0);
    aux_drive(1'b0, 32'h40, 32'h0, 4'h0);
    #1;
    check("rd_rstrb", 32'(mem_rstrb), 32'h1);
    check("rd_wmask", 32'(mem_wmask), 32'h0);
    tick();
    check("rd_ack_n1", 32'(aux_ack), 32'h0);
    tick();
    check("rd_ack_n2", 32'(aux_ack), 32'h1);
    check("rd_data", aux_rdata, 32'hDEAD_BEEF);
    aux_req = 1'b0;

    // Conflict: CPU reads 3 cycles while aux is requesting
    tick();
    cpu_rstrb = 1'b1; cpu_addr = 32'h0;
    aux_drive(1'b0, 32'h80, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("cf_addr", mem_addr, 32'h0);
      check("cf_rstrb", 32'(mem_rstrb), 32'h1);
      check("cf_ack", 32'(aux_ack), 32'h0);
      tick();
    end
    cpu_rstrb = 1'b0;
    #1;
    check("cf_cnt", 32'(conflict_cnt), 32'd3);
    check("cf_issue_addr", mem_addr, 32'h80);
    check("cf_issue_rstrb", 32'(mem_rstrb), 32'h1);
    check("cf_cpu_rdata", cpu_rdata, 32'h0000_0013);
    tick();
    tick();
    check("cf_ack", 32'(aux_ack), 32'h1);
    check("cf_aux_rdata", aux_rdata, 32'h1234_5678);
    aux_req = 1'b0;

    // Data isolation: CPU reads 0x40 then 0x0, aux reads 0x80 next
    tick();
    cpu_rstrb = 1'b1; cpu_addr = 32'h40;
    tick();
    cpu_addr = 32'h0;
    #1;
    check("iso_cpu0", cpu_rdata, 32'hDEAD_BEEF);
    tick();
    cpu_rstrb = 1'b0;
    aux_drive(1'b0, 32'h80, 32'h0, 4'h0);
    #1;
    check("iso_issue", 32'(mem_rstrb), 32'h1);
    check("iso_cpu1", cpu_rdata, 32'h0000_0013);
    tick();
    check("iso_cpu2", cpu_rdata, 32'h0000_0013);
    tick();
    check("iso_ack", 32'(aux_ack), 32'h1);
    check("iso_aux", aux_rdata, 32'h1234_5678);
    check("iso_cpu3", cpu_rdata, 32'h0000_0013);

    // Back-to-back reads with req held; CPU read in the cycle after the first issue
    aux_addr = 32'h40;
    tick();
    #1;
    check("b2b_ack0", 32'(aux_ack), 32'h0);
    check("b2b_issue0", 32'(mem_rstrb), 32'h1);
    tick();
    cpu_rstrb = 1'b1; cpu_addr = 32'h44;
    #1;
    check("b2b_cpu_addr", mem_addr, 32'h44);
    check("b2b_ack1", 32'(aux_ack), 32'h0);
    tick();
    cpu_rstrb = 1'b0;
    #1;
    check("b2b_ack2", 32'(aux_ack), 32'h1);
    check("b2b_aux", aux_rdata, 32'hDEAD_BEEF);
    check("b2b_cpu", cpu_rdata, 32'hCAFE_F00D);
    tick();
    check("b2b_ack3", 32'(aux_ack), 32'h0);
    check("b2b_issue1", 32'(mem_rstrb), 32'h1);
    tick();
    check("b2b_ack4", 32'(aux_ack), 32'h0);
    tick();
    check("b2b_ack5", 32'(aux_ack), 32'h1);
    aux_req = 1'b0;
    tick();
    check("b2b_ack6", 32'(aux_ack), 32'h0);

    // Byte write, zero-mask write, then read back
    aux_drive(1'b1, 32'h41, 32'h11AB_2233, 4'b0100);
    #1;
    check("bw_mask", 32'(mem_wmask), 32'h4);
    tick();
    check("bw_ack", 32'(aux_ack), 32'h1);
    aux_req = 1'b0;
    tick();
    aux_drive(1'b1, 32'h40, 32'h0, 4'h0);
    #1;
    check("z_mask", 32'(mem_wmask), 32'h0);
    check("z_rstrb", 32'(mem_rstrb), 32'h0);
    tick();
    check("z_ack", 32'(aux_ack), 32'h1);
    aux_req = 1'b0;
    tick();
    aux_drive(1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    tick();
    check("bw_ack_rd", 32'(aux_ack), 32'h1);
    check("bw_data", aux_rdata, 32'hDEAB_BEEF);
    aux_req = 1'b0;

    // CPU write passes straight through
    tick();
    cpu_wmask = 4'h3; cpu_addr = 32'h48; cpu_wdata = 32'h0000_A5A5;
    #1;
    check("cw_mask", 32'(mem_wmask), 32'h3);
    check("cw_addr", mem_addr, 32'h48);
    check("cw_wdata", mem_wdata, 32'h0000_A5A5);
    check("cw_rstrb", 32'(mem_rstrb), 32'h0);
    tick();
    cpu_wmask = 4'h0;

    // Reset during RD_WAIT drops the transaction; re-request completes
    aux_drive(1'b0, 32'h80, 32'h0, 4'h0);
    tick();
    rst = 1'b0;
    #1;
    check("rr_ack0", 32'(aux_ack), 32'h0);
    check("rr_cnt", 32'(conflict_cnt), 32'h0);
    check("rr_aux_rdata", aux_rdata, 32'h0);
    check("rr_rstrb", 32'(mem_rstrb), 32'h0);
    tick();
    check("rr_ack1", 32'(aux_ack), 32'h0);
    check("rr_rstrb1", 32'(mem_rstrb), 32'h0);
    rst = 1'b1;
    #1;
    check("rr_issue", 32'(mem_rstrb), 32'h1);
    tick();
    check("rr_ack2", 32'(aux_ack), 32'h0);
    tick();
    check("rr_ack3", 32'(aux_ack), 32'h1);
    check("rr_data", aux_rdata, 32'h1234_5678);
    aux_req = 1'b0;

    // Saturation: 20 blocked cycles
    tick();
    cpu_rstrb = 1'b1; cpu_addr = 32'h0;
    aux_drive(1'b0, 32'h80, 32'h0, 4'h0);
    repeat (14) tick();
    check("sat_14", 32'(s_conflict_cnt), 32'd14);
    repeat (6) tick();
    check("sat_20", 32'(s_conflict_cnt), 32'd15);
    check("cnt_20", 32'(conflict_cnt), 32'd20);
    cpu_rstrb = 1'b0;
    aux_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port unified memory between the CPU core and an auxiliary master (boot loader / debug / DMA port). The CPU has absolute priority and is never stalled; it uses memory only in its fetch, load and store cycles. The auxiliary master is served in the CPU's idle cycles through a req/ack handshake, with one transaction outstanding at a time.
Memory timing is fixed: address and strobe are sampled at the clock edge, read data is valid in the following cycle, and writes commit at the edge where the mask is non-zero.

Parameters:
CNT_W, 16, width of the saturating conflict counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
cpu_addr  in  32  CPU memory address
cpu_rstrb  in  1  CPU read strobe
cpu_wdata  in  32  CPU write data
cpu_wmask  in  4  CPU byte write mask
cpu_rdata  out  32  read data returned to CPU
aux_req  in  1  aux request, level, held until aux_ack
aux_we  in  1  1=write, 0=read; stable while aux_req is high
aux_addr  in  32  aux address; stable while aux_req is high
aux_wdata  in  32  aux write data; stable while aux_req is high
aux_wmask  in  4  aux byte mask for writes; stable while aux_req is high
aux_ack  out  1  one-cycle completion pulse
aux_rdata  out  32  aux read data, registered, valid when aux_ack=1 and held until the next aux read ack
mem_addr  out  32  to memory
mem_rstrb  out  1  to memory
mem_wdata  out  32  to memory
mem_wmask  out  4  to memory
mem_rdata  in  32  from memory, valid the cycle after a read strobe
conflict_cnt  out  CNT_W  cycles aux was blocked by the CPU, saturating

Behaviour:
- cpu_act = cpu_rstrb | (|cpu_wmask).
  - When cpu_act=1, the mem_* outputs are a combinational pass-through of the cpu_* inputs, whatever the arbiter state.
- aux FSM states: IDLE, RD_WAIT, ACK.
- IDLE, aux issue:
  - Condition: aux_req=1 and cpu_act=0.
  - The mem_* outputs are driven from the aux_* inputs in that same cycle.
  - Read: mem_rstrb=1, mem_wmask=0, next state RD_WAIT.
  - Write: mem_rstrb=0, mem_wmask=aux_wmask, next state ACK. A write with aux_wmask=0 still completes and acks.
- IDLE, blocked: aux_req=1 and cpu_act=1 → stay IDLE, conflict_cnt += 1 (saturates at all-ones, no wrap).
- RD_WAIT:
  - aux_rdata <= mem_rdata at the end of the cycle.
  - Next state ACK.
  - The CPU may access memory in this cycle; this does not disturb the capture.
- ACK:
  - aux_ack=1 for exactly this cycle. No aux issue in this cycle.
  - Next state IDLE.
  - The aux master may keep aux_req high; a new transaction starts from IDLE.
- Latency from issue cycle N: write ack in N+1, read ack in N+2. Minimum aux period is 2 cycles for writes, 3 for reads.
- When neither master is active, mem_rstrb=0, mem_wmask=0, and mem_addr/mem_wdata are don't-care (implementation drives the aux values).
- cpu_rdata:
  - Register cpu_rd_q is set to cpu_rstrb each cycle.
  - When cpu_rd_q=1: cpu_rdata = mem_rdata, and cpu_rdata_q <= mem_rdata.
  - Otherwise cpu_rdata = cpu_rdata_q, so aux reads never corrupt data the CPU is still using.
- Simultaneous events:
  - CPU and aux request in the same cycle → CPU wins.
  - An aux read issued in cycle N followed by a CPU read in cycle N+1: aux gets the N data, CPU gets the N+1 data in N+2.
- Reset, rst=0 (asynchronous):
  - state=IDLE, aux_ack=0, aux_rdata=0, cpu_rdata_q=0, cpu_rd_q=0, conflict_cnt=0.
  - mem_rstrb and mem_wmask follow the cpu inputs only. An aux transaction in flight is dropped without ack, and the aux master must re-request.
  - Leaving reset: the FSM is active from the first rising edge with rst=1.

Test Plan:
- aux write, CPU idle: aux_req=1, we=1, addr=0x40, wdata=0xDEADBEEF, wmask=4'hF → mem_wmask=4'hF in issue cycle N, aux_ack=1 at N+1; a later aux read of 0x40 returns 0xDEADBEEF with aux_ack at N+2 of that read.
- Conflict: CPU holds cpu_rstrb=1 for 3 cycles while aux_req=1 → mem_addr=cpu_addr throughout, conflict_cnt=3, aux issues in the first cycle cpu_act=0.
- Data isolation: CPU reads 0x0 (mem returns 0x00000013); aux reads 0x80 (0x12345678) in the next cycle → cpu_rdata stays 0x00000013 after the aux read; aux_rdata=0x12345678 at ack.
- Back-to-back: aux_req held high for 2 reads → acks exactly 3 cycles apart, each a single-cycle pulse.
- Byte write: aux write wmask=4'b0100 to 0x41, then read → only byte 2 of 0x40 changed.
- Reset mid-read: rst=0 while in RD_WAIT → aux_ack never pulses, conflict_cnt=0, state IDLE; aux re-request completes normally.
- Saturation: CNT_W=4, 20 blocked cycles → conflict_cnt=15.
